// File: rtl/ipml_fifo_pkg.sv
// Shared definitions for the ipml prefetch FIFO family.
//   level_width()  : occupancy counter width for a given RAM address width.
//                    Must hold 2**addr_w + prefetch depth (at most 4), so two
//                    extra bits are always enough.
//   PF_DEPTH_MIN/MAX : legal range of the prefetch buffer depth.
package ipml_fifo_pkg;

    localparam int PF_DEPTH_MIN = 2;
    localparam int PF_DEPTH_MAX = 4;

    function automatic int level_width(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/ipml_prefetch_fifo_v2_0_sdpram.sv
// Simple dual-port RAM, DATA_W x 2**ADDR_W, one write port and one read port
// sharing a clock. Read data is registered (1-cycle latency) and holds its
// value when rd_en is low.
// Ports:
//   clk      in  clock, rising edge
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_en    in  read strobe
//   rd_addr  in  read address
//   rd_data  out registered read data
module ipml_prefetch_fifo_v2_0_sdpram
    import ipml_fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ipml_prefetch_fifo_v2_0_sync.sv
// Single-clock first-word-fall-through FIFO: a synchronous-read RAM backed by a
// small circular prefetch buffer so the head word is always presented from
// registers and one pop per cycle can be sustained.
// Handshake: push = wr_en & wr_vld, pop = rd_en & rd_vld. wr_vld depends only
// on registered state; rd_vld/rd_data are driven from registers (prefetch
// buffer or the RAM read register) and hold while rd_vld & ~rd_en.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr             synchronous flush (active-high)
//   wr_data/wr_en/wr_vld   write side
//   rd_data/rd_en/rd_vld   read side (head of FIFO)
//   level           words held (RAM + in-flight read + prefetch buffer)
//   almost_full     level >= AF_THRESH
//   almost_empty    level <= AE_THRESH
//   overflow        sticky: wr_en seen while ~wr_vld
//   underflow       sticky: rd_en seen while ~rd_vld
module ipml_prefetch_fifo_v2_0_sync
    import ipml_fifo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int PF_DEPTH  = 2,
    parameter int AF_THRESH = 1020,
    parameter int AE_THRESH = 2,
    parameter int LEVEL_W   = level_width(ADDR_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_en,
    output logic               wr_vld,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               rd_en,
    output logic               rd_vld,
    output logic [LEVEL_W-1:0] level,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic               underflow
);

    localparam int PF_IW = $clog2(PF_DEPTH);
    localparam int PF_CW = $clog2(PF_DEPTH + 1);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    if (PF_DEPTH < PF_DEPTH_MIN || PF_DEPTH > PF_DEPTH_MAX) begin : g_bad_pf_depth
        $error("PF_DEPTH out of range");
    end

    // RAM pointers carry an extra wrap bit to tell full from empty.
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PF_IW-1:0]   pf_head_q, pf_head_d, pf_tail_q, pf_tail_d;
    logic [PF_CW-1:0]   pf_cnt_q, pf_cnt_d;
    logic [DATA_W-1:0]  pf_buf_q [PF_DEPTH];
    logic [DATA_W-1:0]  pf_buf_d [PF_DEPTH];
    logic               inflight_q, inflight_d;
    logic               wr_vld_q, wr_vld_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               af_q, af_d, ae_q, ae_d, ovf_q, ovf_d, udf_q, udf_d;

    logic               push, pop, pf_wr, pf_deq, ram_empty, rd_issue;
    logic               head_vld;
    logic [DATA_W-1:0]  head_data, ram_rd_data;

    function automatic logic [PF_IW-1:0] pf_next_idx(input logic [PF_IW-1:0] idx);
        return (idx == PF_IW'(PF_DEPTH - 1)) ? '0 : idx + PF_IW'(1);
    endfunction

    // Head of FIFO: the prefetch buffer is older than any in-flight RAM word,
    // so the RAM read register is only shown when the buffer is empty.
    assign head_vld  = (pf_cnt_q != '0) | inflight_q;
    assign head_data = (pf_cnt_q != '0) ? pf_buf_q[pf_head_q] : ram_rd_data;

    always_comb begin
        push      = wr_en & wr_vld_q & ~clr;
        pop       = rd_en & head_vld & ~clr;
        ram_empty = (wr_ptr_q == rd_ptr_q);

        // A returning RAM word is buffered unless it is consumed directly
        // from the RAM read register in the same cycle.
        pf_wr  = inflight_q & ~(pop & (pf_cnt_q == '0));
        pf_deq = pop & (pf_cnt_q != '0);

        pf_cnt_d  = pf_cnt_q + PF_CW'(pf_wr) - PF_CW'(pf_deq);
        pf_head_d = pf_deq ? pf_next_idx(pf_head_q) : pf_head_q;
        pf_tail_d = pf_wr ? pf_next_idx(pf_tail_q) : pf_tail_q;
        pf_buf_d  = pf_buf_q;
        if (pf_wr) begin
            pf_buf_d[pf_tail_q] = ram_rd_data;
        end

        // Issue only if the word can still find a buffer slot when it returns.
        rd_issue   = ~ram_empty & ~clr & (pf_cnt_d < PF_CW'(PF_DEPTH));
        inflight_d = rd_issue;

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        wr_vld_d = ~((wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                     (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]));

        level_d = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
        af_d    = (level_d >= LEVEL_W'(AF_THRESH));
        ae_d    = (level_d <= LEVEL_W'(AE_THRESH));
        ovf_d   = ovf_q | (wr_en & ~wr_vld_q);
        udf_d   = udf_q | (rd_en & ~head_vld);

        // Flush returns to the post-reset state; the RAM is then empty, so the
        // write side is ready again straight away.
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pf_head_d  = '0;
            pf_tail_d  = '0;
            pf_cnt_d   = '0;
            inflight_d = 1'b0;
            wr_vld_d   = 1'b1;
            level_d    = '0;
            af_d       = 1'b0;
            ae_d       = 1'b1;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pf_head_q  <= '0;
            pf_tail_q  <= '0;
            pf_cnt_q   <= '0;
            inflight_q <= 1'b0;
            wr_vld_q   <= 1'b0;
            level_q    <= '0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pf_head_q  <= pf_head_d;
            pf_tail_q  <= pf_tail_d;
            pf_cnt_q   <= pf_cnt_d;
            inflight_q <= inflight_d;
            wr_vld_q   <= wr_vld_d;
            level_q    <= level_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
        pf_buf_q <= pf_buf_d;
    end

    ipml_prefetch_fifo_v2_0_sdpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push & rst_n),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_issue & rst_n),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    assign wr_vld       = wr_vld_q;
    assign rd_vld       = head_vld;
    assign rd_data      = head_vld ? head_data : '0;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0_sync.sv
module tb_ipml_prefetch_fifo_v2_0_sync;

    // clock / reset / DUT
    logic        clk = 1'b0;
    logic        rst_n, clr, wr_en, rd_en;
    logic [15:0] wr_data;
    logic        wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
    logic [15:0] rd_data;
    logic [5:0]  level;

    always #5 clk = ~clk;

    ipml_prefetch_fifo_v2_0_sync #(
        .DATA_W    (16),
        .ADDR_W    (4),
        .PF_DEPTH  (2),
        .AF_THRESH (12),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_vld       (wr_vld),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .rd_vld       (rd_vld),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // scoreboard
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // vector table
    typedef struct packed {
        logic        rst_n, clr, wr_en, rd_en;
        logic [15:0] wr_data;
        logic        wv, rv;
        logic [15:0] rd;
        logic [5:0]  lvl;
        logic        af, ae, ov, un;
    } vec_t;

    function automatic vec_t mk(input logic r, c, we, input logic [15:0] wd, input logic re,
                                input logic wv, rv, input logic [15:0] rd, input logic [5:0] lvl,
                                input logic af, ae, ov, un);
        vec_t v;
        v.rst_n = r;  v.clr = c;  v.wr_en = we;  v.wr_data = wd;  v.rd_en = re;
        v.wv = wv;  v.rv = rv;  v.rd = rd;  v.lvl = lvl;
        v.af = af;  v.ae = ae;  v.ov = ov;  v.un = un;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, n, pushed, popped, cyc, gaps, lvl_bad;

        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

        //            rst clr we data     re | wv rv rd       lvl af ae ov un
        vecs.push_back(mk(0, 0, 1, 16'h1111, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0)); // reset, write ignored
        vecs.push_back(mk(0, 0, 1, 16'h1111, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h1111, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 0)); // release: wr_vld rises
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'hA5A5, 0, 1, 0, 16'h0000, 1, 0, 1, 0, 0)); // push N -> level N+1
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 16'hA5A5, 1, 0, 1, 0, 0)); // head at N+2
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 0)); // pop
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 1)); // rd on empty
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 1)); // sticky
        vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 0)); // clr clears flag
        vecs.push_back(mk(1, 0, 1, 16'h0001, 0, 1, 0, 16'h0000, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0002, 0, 1, 1, 16'h0001, 2, 0, 1, 0, 0)); // level 2: ae still 1
        vecs.push_back(mk(1, 0, 1, 16'h0003, 0, 1, 1, 16'h0001, 3, 0, 0, 0, 0)); // level 3: ae drops
        vecs.push_back(mk(1, 0, 1, 16'h0004, 1, 1, 1, 16'h0002, 3, 0, 0, 0, 0)); // push+pop
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0003, 2, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0004, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; clr = vecs[i].clr; wr_en = vecs[i].wr_en;
            wr_data = vecs[i].wr_data; rd_en = vecs[i].rd_en;
            tick();
            check($sformatf("vec%0d wr_vld", i), wr_vld, vecs[i].wv);
            check($sformatf("vec%0d rd_vld", i), rd_vld, vecs[i].rv);
            check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].rd);
            check($sformatf("vec%0d level", i), level, vecs[i].lvl);
            check($sformatf("vec%0d almost_full", i), almost_full, vecs[i].af);
            check($sformatf("vec%0d almost_empty", i), almost_empty, vecs[i].ae);
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].ov);
            check($sformatf("vec%0d underflow", i), underflow, vecs[i].un);
        end
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

        // Fill with no reads: 16 RAM words + 2 prefetched are accepted.
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 16'(i);
            if (wr_vld) begin
                exp_q.push_back(16'(i));
                acc++;
            end
            tick();
            check($sformatf("fill%0d level", i), level, acc);
            check($sformatf("fill%0d almost_full", i), almost_full, (acc >= 12));
        end
        wr_en = 1'b0;
        check("fill accepted", acc, 18);
        check("fill wr_vld", wr_vld, 0);
        check("fill level", level, 18);
        check("fill overflow", overflow, 1);

        // Drain in order.
        rd_en = 1'b1; n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            if (rd_vld) check($sformatf("drain%0d rd_data", n), rd_data, exp_q.pop_front());
            tick();
            n++;
        end
        rd_en = 1'b0;
        check("drain in time", (n < 40), 1);
        check("drain level", level, 0);
        check("drain overflow sticky", overflow, 1);

        clr = 1'b1; tick(); clr = 1'b0;
        check("clr overflow", overflow, 0);

        // Streaming: continuous push+pop of a 1000-word ramp.
        pushed = 0; popped = 0; cyc = 0; gaps = 0; lvl_bad = 0;
        while (popped < 1000 && cyc < 1200) begin
            wr_en = (pushed < 1000); wr_data = pushed[15:0]; rd_en = 1'b1;
            if (popped > 0 && !rd_vld) gaps++;
            if (popped > 0 && pushed < 1000 && level != 6'd2) lvl_bad++;
            if (rd_vld) begin
                if (exp_q.size() > 0) check($sformatf("stream%0d rd_data", popped), rd_data, exp_q.pop_front());
                else check($sformatf("stream%0d unexpected word", popped), rd_data, 32'hFFFF_FFFF);
                popped++;
            end
            if (wr_en && wr_vld) begin
                exp_q.push_back(pushed[15:0]);
                pushed++;
            end
            tick();
            cyc++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("stream popped", popped, 1000);
        check("stream gaps", gaps, 0);
        check("stream level steady", lvl_bad, 0);
        check("stream underflow from early rd_en", underflow, 1);

        // Flush with 8 words held and rd_en active in the clr cycle.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 16'h0100 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        tick(); tick(); tick();
        check("flush pre level", level, 8);
        check("flush pre rd_data", rd_data, 16'h0100);
        clr = 1'b1; rd_en = 1'b1; wr_en = 1'b1; wr_data = 16'hDEAD;
        tick();
        clr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        check("flush level", level, 0);
        check("flush rd_vld", rd_vld, 0);
        check("flush rd_data", rd_data, 0);
        check("flush underflow", underflow, 0);
        check("flush overflow", overflow, 0);
        check("flush almost_empty", almost_empty, 1);
        check("flush almost_full", almost_full, 0);
        tick(); tick();
        check("flush no late word", rd_vld, 0);
        check("flush level stays", level, 0);
        wr_en = 1'b1; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        tick();
        check("post flush rd_vld", rd_vld, 1);
        check("post flush rd_data", rd_data, 16'hBEEF);
        check("post flush level", level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
